// File: rtl/slide_monitor.sv
// Watches a 16-bit sliding-LED bar, tracks the lit position, measures the step
// period against the 10/20/50 Hz driver rates and latches a sticky protocol fault.
module slide_monitor #(
  parameter int MAX_CNT_DEST = 5000000,
  parameter int TOL          = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_in,
  input  logic        clr,
  output logic [3:0]  pos,
  output logic        pos_valid,
  output logic [1:0]  speed,
  output logic        step_pulse,
  output logic        err
);

  localparam int P10 = 2 * MAX_CNT_DEST;
  localparam int P20 = MAX_CNT_DEST;
  localparam int P50 = (2 * MAX_CNT_DEST) / 5;
  localparam int SAT = P10 + TOL + 1;
  localparam int CW  = $clog2(P10 + TOL + 2);

  localparam logic [CW-1:0] SAT_C = CW'(SAT);
  localparam logic [CW:0]   LO10  = (CW+1)'(P10 - TOL);
  localparam logic [CW:0]   HI10  = (CW+1)'(P10 + TOL);
  localparam logic [CW:0]   LO20  = (CW+1)'(P20 - TOL);
  localparam logic [CW:0]   HI20  = (CW+1)'(P20 + TOL);
  localparam logic [CW:0]   LO50  = (CW+1)'(P50 - TOL);
  localparam logic [CW:0]   HI50  = (CW+1)'(P50 + TOL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   s_q, s_d;
  logic [15:0]   p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pos_q, pos_d;
  logic          pos_valid_q, pos_valid_d;
  logic [1:0]    speed_q, speed_d;
  logic          step_pulse_q, step_pulse_d;
  logic          err_q, err_d;

  logic          s_onehot;
  logic          p_onehot;
  logic          step_seen;
  logic          legal_step;
  logic          bad_sample;
  logic [3:0]    s_idx;
  logic [CW:0]   period;
  logic [1:0]    match_speed;
  logic [CW-1:0] cnt_inc;

  function automatic logic [3:0] idx_of(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign s_onehot   = (s_q != 16'd0) && ((s_q & (s_q - 16'd1)) == 16'd0);
  assign p_onehot   = (p_q != 16'd0) && ((p_q & (p_q - 16'd1)) == 16'd0);
  assign step_seen  = (s_q != p_q);
  assign legal_step = p_onehot &&
                      ((s_q == (p_q << 1)) || ((p_q == 16'h8000) && (s_q == 16'h0001)));
  assign bad_sample = !s_onehot || (step_seen && !legal_step);
  assign s_idx      = idx_of(s_q);
  assign cnt_inc    = (cnt_q == SAT_C) ? cnt_q : cnt_q + CW'(1);

  // The step edge sees the counter one short of the true interval length.
  always_comb begin
    period      = {1'b0, cnt_q} + (CW+1)'(1);
    match_speed = 2'd0;
    if ((period >= LO50) && (period <= HI50)) begin
      match_speed = 2'd3;
    end else if ((period >= LO20) && (period <= HI20)) begin
      match_speed = 2'd2;
    end else if ((period >= LO10) && (period <= HI10)) begin
      match_speed = 2'd1;
    end
  end

  always_comb begin
    s_d          = led_in;
    p_d          = s_q;
    state_d      = state_q;
    cnt_d        = cnt_inc;
    pos_d        = pos_q;
    pos_valid_d  = pos_valid_q;
    speed_d      = speed_q;
    step_pulse_d = 1'b0;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        pos_d       = 4'd0;
        pos_valid_d = 1'b0;
        speed_d     = 2'd0;
        err_d       = 1'b0;
        if (s_onehot) begin
          state_d     = LOCK;
          pos_d       = s_idx;
          pos_valid_d = 1'b1;
        end
      end

      LOCK, TRACK: begin
        if (bad_sample) begin
          cnt_d   = '0;
          speed_d = 2'd0;
          // A clear arriving with the offending sample pre-empts the fault.
          if (clr) begin
            state_d     = IDLE;
            pos_d       = 4'd0;
            pos_valid_d = 1'b0;
            err_d       = 1'b0;
          end else begin
            state_d     = FAULT;
            pos_valid_d = 1'b0;
            err_d       = 1'b1;
          end
        end else if (step_seen) begin
          state_d      = TRACK;
          cnt_d        = '0;
          step_pulse_d = 1'b1;
          pos_d        = s_idx;
          speed_d      = (state_q == TRACK) ? match_speed : 2'd0;
        end else if ((state_q == TRACK) && (cnt_inc == SAT_C)) begin
          speed_d = 2'd0;
        end
      end

      FAULT: begin
        cnt_d       = '0;
        pos_valid_d = 1'b0;
        speed_d     = 2'd0;
        err_d       = 1'b1;
        if (clr) begin
          state_d = IDLE;
          pos_d   = 4'd0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        pos_d       = 4'd0;
        pos_valid_d = 1'b0;
        speed_d     = 2'd0;
        err_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= 16'd0;
      p_q          <= 16'd0;
      cnt_q        <= '0;
      pos_q        <= 4'd0;
      pos_valid_q  <= 1'b0;
      speed_q      <= 2'd0;
      step_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      p_q          <= p_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      speed_q      <= speed_d;
      step_pulse_q <= step_pulse_d;
      err_q        <= err_d;
    end
  end

  assign pos        = pos_q;
  assign pos_valid  = pos_valid_q;
  assign speed      = speed_q;
  assign step_pulse = step_pulse_q;
  assign err        = err_q;

endmodule

// File: tb/tb_slide_monitor.sv
// Self-checking bench for slide_monitor: a vector table, hand-built corner
// sequences, and randomized LED traffic checked against a cycle-count model.
module tb_slide_monitor;

  localparam int MAX = 10;
  localparam int TOL = 1;
  localparam int P10 = 20;
  localparam int P20 = 10;
  localparam int P50 = 4;
  localparam int SAT = P10 + TOL + 1;

  logic        clk;
  logic        rst;
  logic [15:0] led_in;
  logic        clr;
  logic [3:0]  pos;
  logic        pos_valid;
  logic [1:0]  speed;
  logic        step_pulse;
  logic        err;

  int checks;
  int errors;
  int pulse_cnt;

  typedef struct {
    logic [15:0] led;
    logic        c;
    int          e_pos;
    int          e_valid;
    int          e_speed;
    int          e_pulse;
    int          e_err;
  } vec_t;

  vec_t tbl[18];

  slide_monitor #(.MAX_CNT_DEST(MAX), .TOL(TOL)) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .clr        (clr),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .speed      (speed),
    .step_pulse (step_pulse),
    .err        (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at a falling edge, advance n rising edges, sample on falling edges.
  task automatic applyStimulus(input logic [15:0] led, input logic c, input int n);
    led_in = led;
    clr    = c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_pulse) pulse_cnt++;
    end
    clr = 1'b0;
  endtask

  task automatic doReset();
    rst    = 1'b1;
    led_in = 16'd0;
    clr    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic checkAll(input string name, input int e_pos, input int e_valid,
                          input int e_speed, input int e_err);
    checkOutput({name, ".pos"},   int'(pos),       e_pos);
    checkOutput({name, ".valid"}, int'(pos_valid), e_valid);
    checkOutput({name, ".speed"}, int'(speed),     e_speed);
    checkOutput({name, ".err"},   int'(err),       e_err);
  endtask

  function automatic bit oneHot(input logic [15:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int ledIndex(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic int speedFor(input int period);
    if (period >= P50 - TOL && period <= P50 + TOL) return 3;
    if (period >= P20 - TOL && period <= P20 + TOL) return 2;
    if (period >= P10 - TOL && period <= P10 + TOL) return 1;
    return 0;
  endfunction

  // Random LED traffic; the model decides each edge from the two most recent
  // samples and the number of edges since the last accepted step.
  task automatic runRandom(input int ncycles);
    int          mode  = 0;
    int          cyc   = 0;
    int          last  = 0;
    int          rem   = 0;
    int          r;
    int          per;
    int          e_pos = 0, e_valid = 0, e_speed = 0, e_pulse = 0, e_err = 0;
    int          periods[12] = '{3, 4, 5, 9, 10, 11, 15, 19, 20, 21, 24, 30};
    logic [15:0] h1  = 16'd0;
    logic [15:0] h2  = 16'd0;
    logic [15:0] cur = 16'h0001;
    logic [15:0] s, p;
    bit          c, legal;
    for (int k = 0; k < ncycles; k++) begin
      if (rem == 0) begin
        r = $urandom_range(0, 99);
        if (r < 84) begin
          if (oneHot(cur)) cur = {cur[14:0], cur[15]};
          else             cur = 16'(1) << $urandom_range(0, 15);
        end else if (r < 90) begin
          cur = 16'($urandom);
        end else if (r < 95) begin
          cur = 16'(1) << $urandom_range(0, 15);
        end else begin
          cur = 16'd0;
        end
        rem = periods[$urandom_range(0, 11)];
      end
      rem--;
      c      = ($urandom_range(0, 24) == 0);
      led_in = cur;
      clr    = c;
      @(posedge clk);
      @(negedge clk);
      cyc++;

      s       = h1;
      p       = h2;
      e_pulse = 0;
      case (mode)
        0: begin
          if (oneHot(s)) begin
            mode = 1; e_pos = ledIndex(s); e_valid = 1;
          end
        end
        1, 2: begin
          legal = oneHot(p) && oneHot(s) && (ledIndex(s) == (ledIndex(p) + 1) % 16);
          if (!oneHot(s) || (s != p && !legal)) begin
            if (c) begin
              mode = 0; e_pos = 0; e_valid = 0; e_speed = 0; e_err = 0;
            end else begin
              mode = 3; e_valid = 0; e_speed = 0; e_err = 1;
            end
          end else if (s != p) begin
            e_pulse = 1;
            e_pos   = ledIndex(s);
            per     = (cyc - last > SAT + 1) ? SAT + 1 : cyc - last;
            e_speed = (mode == 2) ? speedFor(per) : 0;
            mode    = 2;
            last    = cyc;
          end else if (mode == 2 && cyc - last >= SAT) begin
            e_speed = 0;
          end
        end
        default: begin
          if (c) begin
            mode = 0; e_pos = 0; e_valid = 0; e_speed = 0; e_err = 0;
          end
        end
      endcase
      h2 = h1;
      h1 = cur;

      checkOutput($sformatf("rand%0d.outs", cyc),
                  int'({pos, pos_valid, speed, step_pulse, err}),
                  (e_pos << 5) | (e_valid << 4) | (e_speed << 2) | (e_pulse << 1) | e_err);
    end
    clr = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    led_in    = 16'd0;
    clr       = 1'b0;

    // Walk 1 -> 8 at the 50 Hz rate, clr mid-track, skip fault, clear, relock.
    tbl[0]  = '{16'h0001, 1'b0, 0, 0, 0, 0, 0};
    tbl[1]  = '{16'h0001, 1'b0, 0, 1, 0, 0, 0};
    tbl[2]  = '{16'h0002, 1'b0, 0, 1, 0, 0, 0};
    tbl[3]  = '{16'h0002, 1'b0, 1, 1, 0, 1, 0};
    tbl[4]  = '{16'h0002, 1'b0, 1, 1, 0, 0, 0};
    tbl[5]  = '{16'h0002, 1'b0, 1, 1, 0, 0, 0};
    tbl[6]  = '{16'h0004, 1'b0, 1, 1, 0, 0, 0};
    tbl[7]  = '{16'h0004, 1'b0, 2, 1, 3, 1, 0};
    tbl[8]  = '{16'h0004, 1'b0, 2, 1, 3, 0, 0};
    tbl[9]  = '{16'h0004, 1'b1, 2, 1, 3, 0, 0};
    tbl[10] = '{16'h0008, 1'b0, 2, 1, 3, 0, 0};
    tbl[11] = '{16'h0008, 1'b0, 3, 1, 3, 1, 0};
    tbl[12] = '{16'h0020, 1'b0, 3, 1, 3, 0, 0};
    tbl[13] = '{16'h0020, 1'b0, 3, 0, 0, 0, 1};
    tbl[14] = '{16'h0020, 1'b0, 3, 0, 0, 0, 1};
    tbl[15] = '{16'h0020, 1'b1, 0, 0, 0, 0, 0};
    tbl[16] = '{16'h0020, 1'b0, 5, 1, 0, 0, 0};
    tbl[17] = '{16'h0020, 1'b0, 5, 1, 0, 0, 0};

    doReset();
    checkAll("reset", 0, 0, 0, 0);
    checkOutput("reset.pulse", int'(step_pulse), 0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].led, tbl[i].c, 1);
      checkAll($sformatf("vec%0d", i), tbl[i].e_pos, tbl[i].e_valid, tbl[i].e_speed, tbl[i].e_err);
      checkOutput($sformatf("vec%0d.pulse", i), int'(step_pulse), tbl[i].e_pulse);
    end

    // Lock on a held pattern, then 20-cycle steps reach the 10 Hz code.
    doReset();
    applyStimulus(16'h0001, 1'b0, 5);
    checkAll("hold1", 0, 1, 0, 0);
    checkOutput("hold1.pulses", pulse_cnt, 0);
    applyStimulus(16'h0002, 1'b0, 20);
    checkAll("slow1", 1, 1, 0, 0);
    checkOutput("slow1.pulses", pulse_cnt, 1);
    applyStimulus(16'h0004, 1'b0, 20);
    checkAll("slow2", 2, 1, 1, 0);
    checkOutput("slow2.pulses", pulse_cnt, 2);

    // 4-cycle steps across the 15 -> 0 wrap.
    doReset();
    applyStimulus(16'h2000, 1'b0, 3);
    applyStimulus(16'h4000, 1'b0, 4);
    applyStimulus(16'h8000, 1'b0, 4);
    checkAll("wrap15", 15, 1, 3, 0);
    applyStimulus(16'h0001, 1'b0, 4);
    checkAll("wrap0", 0, 1, 3, 0);

    // Off-rate period, 20 Hz recovery, then a stall long enough to saturate.
    applyStimulus(16'h0001, 1'b0, 11);
    applyStimulus(16'h0002, 1'b0, 3);
    checkAll("per15", 1, 1, 0, 0);
    applyStimulus(16'h0002, 1'b0, 7);
    applyStimulus(16'h0004, 1'b0, 10);
    checkAll("per10", 2, 1, 2, 0);
    applyStimulus(16'h0004, 1'b0, 25);
    checkAll("stall", 2, 1, 0, 0);
    applyStimulus(16'h0008, 1'b0, 3);
    checkAll("afterstall", 3, 1, 0, 0);

    // Jump fault, clear, relock, multi-hot fault, clear.
    doReset();
    applyStimulus(16'h0004, 1'b0, 3);
    applyStimulus(16'h0010, 1'b0, 2);
    checkAll("jump", 2, 0, 0, 1);
    applyStimulus(16'h0010, 1'b0, 3);
    checkAll("jumphold", 2, 0, 0, 1);
    applyStimulus(16'h0010, 1'b1, 1);
    checkAll("clr1", 0, 0, 0, 0);
    applyStimulus(16'h0010, 1'b0, 1);
    checkAll("relock", 4, 1, 0, 0);
    applyStimulus(16'h0003, 1'b0, 2);
    checkAll("multihot", 4, 0, 0, 1);
    applyStimulus(16'h0003, 1'b1, 1);
    checkAll("clr2", 0, 0, 0, 0);
    applyStimulus(16'h0003, 1'b0, 3);
    checkAll("idlemulti", 0, 0, 0, 0);

    // clr together with the offending sample avoids the fault entirely.
    doReset();
    applyStimulus(16'h0001, 1'b0, 3);
    applyStimulus(16'h0002, 1'b0, 2);
    checkAll("pretrack", 1, 1, 0, 0);
    applyStimulus(16'h0008, 1'b0, 1);
    applyStimulus(16'h0008, 1'b1, 1);
    checkAll("clrwin", 0, 0, 0, 0);
    applyStimulus(16'h0008, 1'b0, 2);
    checkAll("clrwin.relock", 3, 1, 0, 0);

    // Asynchronous reset while tracking at 20 Hz.
    doReset();
    applyStimulus(16'h0001, 1'b0, 3);
    applyStimulus(16'h0002, 1'b0, 10);
    applyStimulus(16'h0004, 1'b0, 10);
    checkAll("track20", 2, 1, 2, 0);
    #2 rst = 1'b1;
    #1;
    checkAll("asyncrst", 0, 0, 0, 0);
    checkOutput("asyncrst.pulse", int'(step_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0004, 1'b0, 2);
    checkAll("postrst", 2, 1, 0, 0);

    for (int b = 0; b < 4; b++) begin
      doReset();
      runRandom(600);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
